// File: rtl/spike_aer_tx_if.sv
// AER link bundle: 4-phase req/ack handshake carrying an event address and
// optional timestamp. The transmitter is the master, the off-tile receiver the slave.
interface spike_aer_tx_if #(
  parameter int ADDR_W = 3,
  parameter int TS_W   = 8
);
  logic              aer_req;
  logic [ADDR_W-1:0] aer_addr;
  logic [TS_W-1:0]   aer_ts;
  logic              aer_ack;

  modport master (output aer_req, output aer_addr, output aer_ts, input aer_ack);
  modport slave  (input aer_req, input aer_addr, input aer_ts, output aer_ack);
endinterface

// File: rtl/spike_aer_tx.sv
// AER transmitter: buffers spike lanes as pending events and serialises them,
// round-robin, over a 4-phase req/ack link. Optional timestamping: AER_TIMESTAMP_EN.
module spike_aer_tx #(
  parameter int N_NEURONS = 8,
  parameter int ADDR_W    = $clog2(N_NEURONS),
  parameter int TS_W      = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_NEURONS-1:0] spike_in,
  input  logic                 spike_valid,
  spike_aer_tx_if.master       aer,
  output logic [N_NEURONS-1:0] pending,
  output logic                 overflow,
  output logic                 busy
);

  typedef enum logic [1:0] {IDLE, REQ, RELEASE} state_t;

  state_t              state, state_nxt;
  logic                req_r, req_nxt;
  logic [ADDR_W-1:0]   addr_r, addr_nxt;
  logic [ADDR_W-1:0]   last_addr, last_nxt;
  logic [ADDR_W-1:0]   pick;
  logic [N_NEURONS-1:0] spike_m, clr_mask, pend_nxt;
  logic                ovf_hit;

  // First requesting lane strictly after 'last', wrapping; lane count is a power of 2
  function automatic logic [ADDR_W-1:0] rr_pick(input logic [N_NEURONS-1:0] req,
                                                input logic [ADDR_W-1:0]    last);
    logic [ADDR_W-1:0] idx;
    logic              found;
    rr_pick = last;
    found   = 1'b0;
    for (int k = 1; k <= N_NEURONS; k++) begin
      idx = last + ADDR_W'(k);
      if (!found && req[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

  assign pick = rr_pick(pending, last_addr);

  // A lane granted and acknowledged this edge may be re-armed by a coincident spike
  always_comb begin
    spike_m  = spike_valid ? spike_in : '0;
    clr_mask = '0;
    if (state == REQ && aer.aer_ack)
      clr_mask[addr_r] = 1'b1;
    pend_nxt = (pending & ~clr_mask) | spike_m;
    ovf_hit  = |(spike_m & pending & ~clr_mask);
  end

  always_comb begin
    state_nxt = state;
    req_nxt   = req_r;
    addr_nxt  = addr_r;
    last_nxt  = last_addr;
    case (state)
      IDLE: begin
        if ((|pending) && !aer.aer_ack) begin
          state_nxt = REQ;
          req_nxt   = 1'b1;
          addr_nxt  = pick;
          last_nxt  = pick;
        end
      end
      REQ: begin
        if (aer.aer_ack) begin
          state_nxt = RELEASE;
          req_nxt   = 1'b0;
        end
      end
      RELEASE: begin
        if (!aer.aer_ack)
          state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
        req_nxt   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      req_r     <= 1'b0;
      addr_r    <= '0;
      last_addr <= ADDR_W'(N_NEURONS - 1);
      pending   <= '0;
      overflow  <= 1'b0;
    end else begin
      state     <= state_nxt;
      req_r     <= req_nxt;
      addr_r    <= addr_nxt;
      last_addr <= last_nxt;
      pending   <= pend_nxt;
      overflow  <= overflow | ovf_hit;
    end
  end

`ifdef AER_TIMESTAMP_EN
  logic [TS_W-1:0] ts_cnt;
  logic [TS_W-1:0] ts_r;

  // Timestamp captures the free-running count at the moment the request is launched
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ts_cnt <= '0;
      ts_r   <= '0;
    end else begin
      ts_cnt <= ts_cnt + 1'b1;
      if (state == IDLE && state_nxt == REQ)
        ts_r <= ts_cnt;
    end
  end

  assign aer.aer_ts = ts_r;
`else
  assign aer.aer_ts = '0;
`endif

  assign aer.aer_req  = req_r;
  assign aer.aer_addr = addr_r;
  assign busy         = (state != IDLE);

endmodule
